// File: rtl/ruler_search_sequencer.sv
// Central step sequencer for the Golomb-ruler mark-counter assembly (one enabled level, one lock pulse per step).
// marks_in/best_marks pack m0 in the top PVW bits down to mNUMPOS in the bottom bits; `STEP_BUDGET_EN adds a step budget.
module ruler_search_sequencer #(
    parameter int NUMPOS   = 5,
    parameter int PVW      = 6,
    parameter int PNW      = 3,
    parameter int FIRSTVAR = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [PVW-1:0]            init_limit,
    input  logic                      step_ready,
    input  logic [PNW-1:0]            next_enabled,
    input  logic [(NUMPOS+1)*PVW-1:0] marks_in,
`ifdef STEP_BUDGET_EN
    input  logic [31:0]               step_budget,
    output logic                      aborted,
`endif
    output logic [PNW-1:0]            enabled,
    output logic                      globalready,
    output logic [PVW-1:0]            limit,
    output logic                      found,
    output logic [(NUMPOS+1)*PVW-1:0] best_marks,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               step_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = (NUMPOS + 1) * PVW;
    localparam logic [PNW-1:0] LVL_ZERO  = PNW'(0);
    localparam logic [PNW-1:0] LVL_LAST  = PNW'(NUMPOS);
    localparam logic [PNW-1:0] LVL_FULL  = PNW'(NUMPOS + 1);
    localparam logic [PNW-1:0] LVL_FIRST = PNW'(FIRSTVAR);
    localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [PNW-1:0] enabled_q, enabled_d;
    logic           globalready_q, globalready_d;
    logic [PVW-1:0] limit_q, limit_d;
    logic           found_q, found_d;
    logic [MW-1:0]  best_marks_q, best_marks_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [31:0]    step_count_q, step_count_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [TW-1:0]  tmo_inc_s;
`ifdef STEP_BUDGET_EN
    logic [31:0]    budget_q, budget_d;
    logic           aborted_q, aborted_d;
`endif

    assign tmo_inc_s = tmo_q + TW'(1);

    // Next-state and registered-output computation for the step handshake sequencer.
    always_comb begin
        state_d       = state_q;
        enabled_d     = enabled_q;
        globalready_d = globalready_q;
        limit_d       = limit_q;
        found_d       = 1'b0;
        best_marks_d  = best_marks_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        step_count_d  = step_count_q;
        tmo_d         = tmo_q;
`ifdef STEP_BUDGET_EN
        budget_d      = budget_q;
        aborted_d     = aborted_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    limit_d       = init_limit;
                    enabled_d     = LVL_FIRST;
                    globalready_d = 1'b0;
                    best_marks_d  = '0;
                    step_count_d  = 32'd0;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    busy_d        = 1'b1;
                    tmo_d         = '0;
`ifdef STEP_BUDGET_EN
                    budget_d      = step_budget;
                    aborted_d     = 1'b0;
`endif
                    state_d       = ST_ARM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARM: begin
                // The lock was low for this whole cycle; raise it for the issue phase.
                globalready_d = 1'b1;
                state_d       = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tmo_inc_s == TMO_LIMIT) begin
                    globalready_d = 1'b0;
                    error_d       = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = ST_ERROR;
                end else if (!step_ready) begin
                    globalready_d = 1'b0;
                    tmo_d         = tmo_inc_s;
                    state_d       = ST_WAIT;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_WAIT: begin
                if (tmo_inc_s == TMO_LIMIT) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ERROR;
                end else if (step_ready) begin
                    step_count_d = (step_count_q == 32'hFFFF_FFFF) ? step_count_q : step_count_q + 32'd1;
                    state_d      = ST_EVAL;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_EVAL: begin
                if (next_enabled == LVL_FULL) begin
                    best_marks_d = marks_in;
                    limit_d      = marks_in[PVW-1:0];
                    found_d      = 1'b1;
                    enabled_d    = LVL_LAST;
                    tmo_d        = '0;
                    state_d      = ST_ARM;
                end else if (next_enabled == LVL_ZERO) begin
                    enabled_d = LVL_ZERO;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else if (next_enabled > LVL_FULL) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    enabled_d = next_enabled;
                    tmo_d     = '0;
                    state_d   = ST_ARM;
                end
`ifdef STEP_BUDGET_EN
                // A spent budget ends the search but keeps any ruler captured in this very step.
                if ((state_d == ST_ARM) && (budget_q != 32'd0) && (step_count_q == budget_q)) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    aborted_d = aborted_q;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any search in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            enabled_q     <= '0;
            globalready_q <= 1'b0;
            limit_q       <= '0;
            found_q       <= 1'b0;
            best_marks_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            step_count_q  <= 32'd0;
            tmo_q         <= '0;
`ifdef STEP_BUDGET_EN
            budget_q      <= 32'd0;
            aborted_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            enabled_q     <= enabled_d;
            globalready_q <= globalready_d;
            limit_q       <= limit_d;
            found_q       <= found_d;
            best_marks_q  <= best_marks_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            step_count_q  <= step_count_d;
            tmo_q         <= tmo_d;
`ifdef STEP_BUDGET_EN
            budget_q      <= budget_d;
            aborted_q     <= aborted_d;
`endif
        end
    end

    assign enabled     = enabled_q;
    assign globalready = globalready_q;
    assign limit       = limit_q;
    assign found       = found_q;
    assign best_marks  = best_marks_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign step_count  = step_count_q;
`ifdef STEP_BUDGET_EN
    assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_ruler_search_sequencer.sv
// Self-checking bench: a behavioural Golomb mark-counter model drives the sequencer, a scoreboard checks captured rulers.
// Build with +define+STEP_BUDGET_EN to also exercise the step budget.
module tb_ruler_search_sequencer;
    localparam int NUMPOS   = 5;
    localparam int PVW      = 6;
    localparam int PNW      = 3;
    localparam int FIRSTVAR = 1;
    localparam int TIMEOUT  = 255;
    localparam int MW       = (NUMPOS + 1) * PVW;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [PVW-1:0] init_limit = '0;
    logic           step_ready = 1'b1;
    logic [PNW-1:0] next_enabled = '0;
    logic [MW-1:0]  marks_in = '0;
    logic [PNW-1:0] enabled;
    logic           globalready;
    logic [PVW-1:0] limit;
    logic           found;
    logic [MW-1:0]  best_marks;
    logic           busy;
    logic           done;
    logic           error;
    logic [31:0]    step_count;
`ifdef STEP_BUDGET_EN
    logic [31:0]    step_budget = 32'd0;
    logic           aborted;
`endif

    ruler_search_sequencer #(
        .NUMPOS(NUMPOS), .PVW(PVW), .PNW(PNW), .FIRSTVAR(FIRSTVAR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .init_limit(init_limit),
        .step_ready(step_ready), .next_enabled(next_enabled), .marks_in(marks_in),
`ifdef STEP_BUDGET_EN
        .step_budget(step_budget), .aborted(aborted),
`endif
        .enabled(enabled), .globalready(globalready), .limit(limit), .found(found),
        .best_marks(best_marks), .busy(busy), .done(done), .error(error), .step_count(step_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int found_cnt = 0;
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] exp_m;

    // Model state: current mark positions and the limit the counters believe in.
    int m [0:NUMPOS];
    int mlimit;
    // Shortest possible span of a Golomb ruler with k marks, used to prune hopeless positions.
    int gmin [0:NUMPOS+1] = '{0, 0, 1, 3, 6, 11, 17};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passes++;
    endtask

    function automatic logic [MW-1:0] pack_model();
        logic [MW-1:0] v = '0;
        for (int i = 0; i <= NUMPOS; i++) v[(NUMPOS - i) * PVW +: PVW] = PVW'(m[i]);
        return v;
    endfunction

    function automatic logic [MW-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
        int t [0:5];
        logic [MW-1:0] v = '0;
        t = '{a0, a1, a2, a3, a4, a5};
        for (int i = 0; i <= NUMPOS; i++) v[(NUMPOS - i) * PVW +: PVW] = PVW'(t[i]);
        return v;
    endfunction

    function automatic bit diffs_ok(input int lvl, input int c);
        bit used [0:63];
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        for (int i = 0; i < lvl; i++)
            for (int j = i + 1; j < lvl; j++) used[m[j] - m[i]] = 1'b1;
        for (int k = 0; k < lvl; k++) if (used[c - m[k]]) return 1'b0;
        return 1'b1;
    endfunction

    // One counter step at level lvl: advance to the next legal position or climb.
    function automatic int do_step(input int lvl);
        int c = m[lvl] + 1;
        int span = gmin[NUMPOS - lvl + 1];
        while (c + span <= mlimit - 1) begin
            if (diffs_ok(lvl, c)) break;
            c++;
        end
        if (c + span <= mlimit - 1) begin
            m[lvl] = c;
            if (lvl < NUMPOS) m[lvl + 1] = c;
            return lvl + 1;
        end
        return lvl - 1;
    endfunction

    task automatic pulse_start(input int ilim);
        @(negedge clock);
        init_limit = PVW'(ilim);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_gr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (globalready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_search(input int ilim, input int budget, output int steps);
        int exp_lvl = FIRSTVAR;
        int nxt;
        int fb;
        bit ok;
        bit fin = 1'b0;
        steps = 0;
        for (int i = 0; i <= NUMPOS; i++) m[i] = 0;
        mlimit = ilim;
        marks_in = pack_model();
`ifdef STEP_BUDGET_EN
        step_budget = 32'(budget);
`endif
        pulse_start(ilim);
        chk("start_busy", busy, 1);
        chk("start_limit", limit, ilim);
        chk("start_best", best_marks, 0);
        chk("start_enabled", enabled, FIRSTVAR);
        chk("start_err_clr", {done, error}, 0);
        fb = checks - passes;
        while (!fin) begin
            wait_gr(ok);
            chk("issue_seen", ok, 1);
            if (!ok) break;
            chk("step_enabled", enabled, exp_lvl);
            chk("step_limit", limit, mlimit);
            if (checks - passes != fb) break;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            step_ready = 1'b0;
            nxt = do_step(exp_lvl);
            steps++;
            next_enabled = PNW'(nxt);
            marks_in = pack_model();
            repeat ($urandom_range(1, 3)) @(negedge clock);
            step_ready = 1'b1;
            if (nxt == NUMPOS + 1) begin
                exp_q.push_back(pack_model());
                mlimit = m[NUMPOS];
                exp_lvl = NUMPOS;
            end else begin
                exp_lvl = nxt;
            end
            if (nxt == 0) fin = 1'b1;
            if (budget != 0 && steps == budget) fin = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done || error) break;
        end
        chk("end_done", done, 1);
        chk("end_error", error, 0);
        chk("end_busy", busy, 0);
        chk("end_gr", globalready, 0);
        chk("end_steps", step_count, steps);
        chk("sb_drained", exp_q.size(), 0);
`ifdef STEP_BUDGET_EN
        chk("end_aborted", aborted, (budget != 0) ? 1 : 0);
`endif
    endtask

    // Scoreboard monitor: every found pulse must match the oldest ruler the model completed.
    always @(negedge clock) begin
        if (reset && found) begin
            found_cnt++;
            chk("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_m = exp_q.pop_front();
                chk("found_marks", best_marks, exp_m);
                chk("found_limit", limit, exp_m[PVW-1:0]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int steps;
        int f0;
        int k;
        bit ok;
        repeat (3) @(negedge clock);
        chk("rst_outputs", {enabled, globalready, limit, found, busy, done, error}, 0);
        chk("rst_best", best_marks, 0);
        chk("rst_count", step_count, 0);
        reset = 1'b1;

        f0 = found_cnt;
        run_search(18, 0, steps);
        chk("r18_found", (found_cnt - f0) >= 1, 1);
        chk("r18_best", best_marks, pack6(0, 1, 4, 10, 12, 17));
        chk("r18_limit", limit, 17);
        chk("r18_enabled", enabled, 0);

        f0 = found_cnt;
        run_search(17, 0, steps);
        chk("r17_nofound", found_cnt - f0, 0);
        chk("r17_best", best_marks, 0);
        chk("r17_limit", limit, 17);

        pulse_start(20);
        wait_gr(ok);
        chk("tmo_issue_seen", ok, 1);
        k = 0;
        while (!error && k < 400) begin
            @(negedge clock);
            k++;
            if (k == 10) begin
                start = 1'b1;
                init_limit = 6'd5;
            end else begin
                start = 1'b0;
            end
        end
        chk("tmo_cycles", k, TIMEOUT);
        chk("tmo_error", error, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_gr", globalready, 0);
        chk("tmo_limit_kept", limit, 20);

        run_search(0, 0, steps);
        chk("first_climb_steps", step_count, 1);
        chk("first_climb_enabled", enabled, 0);

        pulse_start(9);
        wait_gr(ok);
        chk("rstw_issue_seen", ok, 1);
        @(negedge clock);
        step_ready = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rstw_outputs", {enabled, globalready, limit, found, busy, done, error}, 0);
        chk("rstw_count", step_count, 0);
        @(negedge clock);
        step_ready = 1'b1;
        reset = 1'b1;
        run_search(12, 0, steps);
        chk("rstw_fresh_steps", step_count, 1);

`ifdef STEP_BUDGET_EN
        run_search(18, 10, steps);
        chk("budget_steps", step_count, 10);
        chk("budget_aborted", aborted, 1);
        chk("budget_done", done, 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
